// File: rtl/led_bank_arbiter.sv
// Round-robin owner arbitration for a shared 4-bit LED bank, with a hold-time
// limit under contention and per-owner PWM dimming of the driven pattern.
module led_bank_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         MAX_HOLD     = 1000000,
  parameter int         PWM_BITS     = 4,
  parameter logic [3:0] IDLE_PATTERN = 4'b0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [4*NUM_REQ-1:0]          pattern,
  input  logic [PWM_BITS*NUM_REQ-1:0]   duty,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [3:0]                    leds
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state;
  logic [OW-1:0]         last_ptr;
  logic [HW-1:0]         hold_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;

  logic [OW-1:0]         sel;
  logic                  any_req;
  logic                  others_waiting;
  logic [PWM_BITS-1:0]   duty_owner;
  logic [3:0]            pattern_owner;
  logic                  pwm_on;

  // Next owner: first requester after last_ptr, wrapping; scanned from the far
  // end so the nearest candidate is written last and wins.
  always_comb begin
    sel = {OW{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      sel = req[(int'(last_ptr) + k) % NUM_REQ] ? OW'((int'(last_ptr) + k) % NUM_REQ) : sel;
    end
    any_req        = |req;
    others_waiting = |(req & ~(ONE << owner));
    duty_owner     = duty[int'(owner)*PWM_BITS +: PWM_BITS];
    pattern_owner  = pattern[int'(owner)*4 +: 4];
    pwm_on         = (duty_owner == {PWM_BITS{1'b1}}) || (pwm_cnt < duty_owner);
  end

  // Ownership FSM: grant, hold with preemption, one-cycle release gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= {NUM_REQ{1'b0}};
      busy     <= 1'b0;
      owner    <= {OW{1'b0}};
      hold_cnt <= {HW{1'b0}};
      last_ptr <= OW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= sel;
            gnt      <= ONE << sel;
            busy     <= 1'b1;
            hold_cnt <= {HW{1'b0}};
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            gnt   <= {NUM_REQ{1'b0}};
            busy  <= 1'b0;
            state <= RELEASE;
          end else if (hold_cnt == HOLD_LAST && others_waiting) begin
            gnt   <= {NUM_REQ{1'b0}};
            busy  <= 1'b0;
            state <= RELEASE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RELEASE: begin
          last_ptr <= owner;
          state    <= IDLE;
        end
        default: begin
          gnt   <= {NUM_REQ{1'b0}};
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running PWM counter and registered LED drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= {PWM_BITS{1'b0}};
      leds    <= IDLE_PATTERN;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (state == GRANT) begin
        leds <= pwm_on ? pattern_owner : 4'b0000;
      end else begin
        leds <= IDLE_PATTERN;
      end
    end
  end

endmodule
